// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave transmit path: SDA output-select codes,
// transmit FSM states and the default transfer width.
package i2c_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // SDA_LOW and SDA_HIGH belong to the receive/ACK controller sharing the select stage.
    typedef enum logic [1:0] {
        SDA_IDLE = 2'b00,
        SDA_LOW  = 2'b01,
        SDA_HIGH = 2'b10,
        SDA_TX   = 2'b11
    } sda_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FALL,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_DONE
    } tx_state_t;

endpackage

// File: rtl/i2c_piso.sv
// Parallel-load, MSB-first shift register feeding the I2C transmit bit.
module i2c_piso
    import i2c_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic             serial_out
);

    logic [WIDTH-1:0] shift_reg;

    // Load wins over shift so a back-to-back byte replaces the finished one cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= par_in;
        end else if (shift_en) begin
            shift_reg <= shift_reg << 1;
        end
    end

    assign serial_out = shift_reg[WIDTH-1];

endmodule

// File: rtl/i2c_tx_ctrl.sv
// I2C slave transmit controller: serialises a byte on SCL falls and collects the master ACK.
// Optional SCL-stall abort is enabled by defining I2C_TX_TIMEOUT_EN (adds the timeout port).
module i2c_tx_ctrl
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef I2C_TX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_rise,
    input  logic                  scl_fall,
    input  logic                  start_found,
    input  logic                  stop_found,
    input  logic                  sda_in,
    input  logic                  tx_req,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic [1:0]            sda_mode,
    output logic                  busy,
    output logic                  ack_rcvd,
    output logic                  nack_rcvd
`ifdef I2C_TX_TIMEOUT_EN
    , output logic                timeout
`endif
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             acked, acked_nxt;
    logic             ack_nxt, nack_nxt;
    logic             piso_load, piso_shift;
    logic             abort, to_hit;

    i2c_piso #(.WIDTH(DATA_WIDTH)) u_piso (
        .clk        (clk),
        .rst        (rst),
        .load       (piso_load),
        .shift_en   (piso_shift),
        .par_in     (tx_data),
        .serial_out (tx_out)
    );

`ifdef I2C_TX_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state != ST_IDLE) && !(scl_rise || scl_fall) &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= to_hit;
            if (state == ST_IDLE || scl_rise || scl_fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            acked     <= 1'b0;
            ack_rcvd  <= 1'b0;
            nack_rcvd <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            acked     <= acked_nxt;
            ack_rcvd  <= ack_nxt;
            nack_rcvd <= nack_nxt;
        end
    end

    assign abort = (start_found || stop_found) && (state != ST_IDLE);

    // Bus events are only acted on in priority order: abort, then scl_fall, then scl_rise.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        acked_nxt   = acked;
        ack_nxt     = 1'b0;
        nack_nxt    = 1'b0;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        if (abort || to_hit) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_req && tx_ready) begin
                        piso_load = 1'b1;
                        state_nxt = ST_WAIT_FALL;
                    end
                end
                ST_WAIT_FALL: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (scl_fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = ST_ACK_WAIT;
                        end else begin
                            piso_shift  = 1'b1;
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                ST_ACK_WAIT: begin
                    if (!scl_fall && scl_rise) begin
                        acked_nxt = !sda_in;
                        ack_nxt   = !sda_in;
                        nack_nxt  = sda_in;
                        state_nxt = ST_ACK_DONE;
                    end
                end
                ST_ACK_DONE: begin
                    if (scl_fall) begin
                        if (acked && tx_req) begin
                            piso_load   = 1'b1;
                            bit_cnt_nxt = '0;
                            state_nxt   = ST_SHIFT;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign sda_mode = (state == ST_SHIFT) ? SDA_TX : SDA_IDLE;

endmodule

// File: tb/tb_i2c_tx_ctrl.sv
// Scoreboard bench for i2c_tx_ctrl: expected bits and ACK results are queued at load
// time and checked as the controller presents them; covers I2C_TX_TIMEOUT_EN when defined.
module tb_i2c_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_rise = 1'b0;
    logic       scl_fall = 1'b0;
    logic       start_found = 1'b0;
    logic       stop_found = 1'b0;
    logic       sda_in = 1'b1;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx_out;
    logic [1:0] sda_mode;
    logic       busy;
    logic       ack_rcvd;
    logic       nack_rcvd;
`ifdef I2C_TX_TIMEOUT_EN
    logic       timeout;
`endif

    int compared_cnt = 0;
    int mismatch_cnt = 0;

    logic       bit_q[$];
    logic [1:0] resp_q[$];
    logic       fall_seen = 1'b0;
    logic       rise_seen = 1'b0;

    i2c_tx_ctrl #(
        .DATA_WIDTH (8)
`ifdef I2C_TX_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_found (start_found),
        .stop_found  (stop_found),
        .sda_in      (sda_in),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_out      (tx_out),
        .sda_mode    (sda_mode),
        .busy        (busy),
        .ack_rcvd    (ack_rcvd),
        .nack_rcvd   (nack_rcvd)
`ifdef I2C_TX_TIMEOUT_EN
        , .timeout   (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Record which SCL pulses the DUT consumed on each edge so outputs can be tied to them.
    always @(posedge clk) begin
        fall_seen <= scl_fall;
        rise_seen <= scl_rise;
    end

    always @(negedge clk) begin
        if (!rst && fall_seen && sda_mode == 2'b11) begin
            if (bit_q.size() == 0) begin
                checkOutput("unexpected_bit", {30'd0, sda_mode}, 32'd0);
            end else begin
                checkOutput("tx_bit", {31'd0, tx_out}, {31'd0, bit_q.pop_front()});
            end
        end
        if (ack_rcvd || nack_rcvd) begin
            checkOutput("resp_timing", {31'd0, rise_seen}, 32'd1);
            if (resp_q.size() == 0) begin
                checkOutput("unexpected_resp", {30'd0, ack_rcvd, nack_rcvd}, 32'd0);
            end else begin
                checkOutput("ack_nack", {30'd0, ack_rcvd, nack_rcvd}, {30'd0, resp_q.pop_front()});
            end
        end
    end

    task automatic pushExpect(input logic [7:0] data, input logic ack, input int nbits, input logic want_resp);
        logic [7:0] d;
        d = data;
        for (int i = 0; i < nbits; i++) begin
            bit_q.push_back(d[7 - i]);
        end
        if (want_resp) resp_q.push_back(ack ? 2'b10 : 2'b01);
    endtask

    task automatic loadByte(input logic [7:0] data);
        tx_req  = 1'b1;
        tx_data = data;
        tick(1);
        tx_req  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic ack);
        pushExpect(data, ack, 8, 1'b1);
        loadByte(data);
    endtask

    task automatic pulseFall();
        scl_fall = 1'b1;
        tick(1);
        scl_fall = 1'b0;
        tick(2);
    endtask

    task automatic pulseRise(input logic sda);
        sda_in   = sda;
        scl_rise = 1'b1;
        tick(1);
        scl_rise = 1'b0;
        tick(2);
    endtask

    // Eight data periods plus the ACK period; the closing fall is left to the caller.
    task automatic runByte(input logic ack);
        for (int i = 0; i < 9; i++) begin
            pulseFall();
            pulseRise((i == 8) ? !ack : 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rnd;
        logic       rnd_ack;

        tick(3);
        rst = 1'b0;
        checkOutput("rst_sda_mode", {30'd0, sda_mode}, 32'd0);
        checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_tx_out", {31'd0, tx_out}, 32'd0);
        checkOutput("rst_pulses", {30'd0, ack_rcvd, nack_rcvd}, 32'd0);

        $display("[TB] byte A5 with ACK");
        applyStimulus(8'hA5, 1'b1);
        checkOutput("load_busy", {31'd0, busy}, 32'd1);
        checkOutput("load_tx_ready", {31'd0, tx_ready}, 32'd0);
        checkOutput("wait_fall_sda_mode", {30'd0, sda_mode}, 32'd0);
        runByte(1'b1);
        checkOutput("ack_slot_sda_mode", {30'd0, sda_mode}, 32'd0);
        pulseFall();
        checkOutput("a5_end_tx_ready", {31'd0, tx_ready}, 32'd1);

        $display("[TB] byte 3C with NACK and tx_req held");
        applyStimulus(8'h3C, 1'b0);
        runByte(1'b0);
        tx_req  = 1'b1;
        tx_data = 8'h3C;
        tick(2);
        checkOutput("nack_done_tx_ready", {31'd0, tx_ready}, 32'd0);
        scl_fall = 1'b1;
        tick(1);
        scl_fall = 1'b0;
        checkOutput("nack_idle_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("nack_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("nack_idle_sda_mode", {30'd0, sda_mode}, 32'd0);
        tick(1);
        tx_req = 1'b0;
        checkOutput("idle_accepts_req", {31'd0, busy}, 32'd1);
        stop_found = 1'b1;
        tick(1);
        stop_found = 1'b0;
        checkOutput("stop_wait_busy", {31'd0, busy}, 32'd0);
        tick(2);

        $display("[TB] back-to-back FF then 00");
        applyStimulus(8'hFF, 1'b1);
        runByte(1'b1);
        pushExpect(8'h00, 1'b1, 8, 1'b1);
        tx_req  = 1'b1;
        tx_data = 8'h00;
        pulseFall();
        tx_req  = 1'b0;
        checkOutput("b2b_sda_mode", {30'd0, sda_mode}, 32'd3);
        checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
        // The first period of the second byte already happened on the fall above.
        pulseRise(1'b1);
        for (int i = 0; i < 8; i++) begin
            pulseFall();
            pulseRise((i == 7) ? 1'b0 : 1'b1);
        end
        pulseFall();
        checkOutput("b2b_end_tx_ready", {31'd0, tx_ready}, 32'd1);

        $display("[TB] stop after third bit of 81");
        pushExpect(8'h81, 1'b1, 3, 1'b0);
        loadByte(8'h81);
        for (int i = 0; i < 3; i++) begin
            pulseFall();
            pulseRise(1'b0);
        end
        stop_found = 1'b1;
        tick(1);
        stop_found = 1'b0;
        checkOutput("stop_sda_mode", {30'd0, sda_mode}, 32'd0);
        checkOutput("stop_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("stop_pulses", {30'd0, ack_rcvd, nack_rcvd}, 32'd0);
        tick(4);

        $display("[TB] reset mid-shift");
        pushExpect(8'hC3, 1'b1, 2, 1'b0);
        loadByte(8'hC3);
        pulseFall();
        pulseRise(1'b0);
        pulseFall();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checkOutput("midrst_sda_mode", {30'd0, sda_mode}, 32'd0);
        checkOutput("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_tx_out", {31'd0, tx_out}, 32'd0);

        $display("[TB] random bytes");
        for (int n = 0; n < 4; n++) begin
            rnd     = 8'($urandom_range(0, 255));
            rnd_ack = 1'($urandom_range(0, 1));
            applyStimulus(rnd, rnd_ack);
            runByte(rnd_ack);
            pulseFall();
            checkOutput("rnd_end_tx_ready", {31'd0, tx_ready}, 32'd1);
        end

        $display("[TB] start abort in ack wait");
        pushExpect(8'h5A, 1'b1, 8, 1'b0);
        loadByte(8'h5A);
        for (int i = 0; i < 9; i++) begin
            pulseFall();
            if (i < 8) pulseRise(1'b0);
        end
        start_found = 1'b1;
        sda_in      = 1'b0;
        scl_rise    = 1'b1;
        tick(1);
        start_found = 1'b0;
        scl_rise    = 1'b0;
        checkOutput("start_abort_busy", {31'd0, busy}, 32'd0);
        tick(3);

`ifdef I2C_TX_TIMEOUT_EN
        $display("[TB] timeout with stalled SCL");
        begin
            int waited;
            waited = 0;
            loadByte(8'h11);
            for (int n = 1; n <= 40; n++) begin
                tick(1);
                if (timeout) begin
                    waited = n;
                    break;
                end
            end
            checkOutput("timeout_delay", 32'(waited), 32'd16);
            checkOutput("timeout_idle", {31'd0, tx_ready}, 32'd1);
            tick(1);
            checkOutput("timeout_one_cycle", {31'd0, timeout}, 32'd0);
        end
`else
        $display("[TB] stalled SCL waits indefinitely");
        loadByte(8'h11);
        tick(60);
        checkOutput("stall_still_busy", {31'd0, busy}, 32'd1);
        stop_found = 1'b1;
        tick(1);
        stop_found = 1'b0;
`endif

        tick(4);
        checkOutput("bit_q_drained", 32'(bit_q.size()), 32'd0);
        checkOutput("resp_q_drained", 32'(resp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
